smi_phy_manager: RTL and testbench
==================================

// Module: smi_phy_manager
// PURPOSE
//  Management sequencer directly upstream of smi_device on the Nexys4 Ethernet path.
//  After reset it soft-resets the LAN8720 PHY over SMI and enables/restarts auto-negotiation.
//  It then polls BMSR periodically and reads the special control/status register on link-up.
//  It publishes link_up, speed and duplex to the MAC/RMII logic.
//  It owns smi_device's request side (do_read/do_write/phy_addr/reg_addr/in_data) and consumes out_data/out_data_valid.
// PARAMETERS
//  PHY_ADDR          5'd1        SMI address of the PHY
//  POWERUP_CYCLES    1_000_000   clocks to wait after rst before first SMI access (10 ms)
//  WRITE_WAIT_CYCLES 3000        clocks allowed for one SMI write frame (no write-done from smi_device)
//  READ_TIMEOUT      4096        max clocks from do_read to out_data_valid
//  POLL_INTERVAL     10_000_000  clocks between BMSR polls (100 ms)
//  RESET_POLL_MAX    16          max BMCR reads waiting for soft-reset bit 15 to clear
// PORTS
//  clk_100mhz     in   1   system clock, 100 MHz
//  rst            in   1   synchronous, active-high reset
//  phy_addr       out  5   to smi_device; constant PHY_ADDR
//  reg_addr       out  5   to smi_device; register of current transaction
//  in_data        out  16  to smi_device; write data
//  do_read        out  1   to smi_device; 1-cycle read request pulse
//  do_write       out  1   to smi_device; 1-cycle write request pulse
//  out_data       in   16  from smi_device; read data, valid with out_data_valid
//  out_data_valid in   1   from smi_device; 1-cycle read-complete pulse
//  init_done      out  1   high once auto-negotiation has been started
//  link_up        out  1   last polled link status
//  speed_100      out  1   1 = 100 Mb/s, 0 = 10 Mb/s (valid while link_up)
//  full_duplex    out  1   1 = full duplex (valid while link_up)
//  link_change    out  1   1-cycle pulse whenever link_up toggles
//  smi_timeout    out  1   sticky; set on any read timeout, cleared only by rst
//  init_fault     out  1   sticky; set if BMCR.15 fails to clear within RESET_POLL_MAX reads
// BEHAVIOUR
//  Reset: all outputs 0 except phy_addr = PHY_ADDR; state = S_POWERUP; timer loaded with POWERUP_CYCLES.
//  Request rule:
//   - do_read/do_write are never high together, and never re-issued until the previous transaction completes.
//   - reg_addr/in_data are driven the cycle of the pulse and held stable until completion.
//  Read completion: first out_data_valid in a *_WAIT state.
//   - out_data is captured that cycle; out_data_valid seen in any other state is ignored.
//   - No valid within READ_TIMEOUT clocks => timeout path.
//  Write completion: WRITE_WAIT_CYCLES after the do_write pulse.
//  States:
//   - S_POWERUP: timer expiry -> S_RST_WR.
//   - S_RST_WR: write reg 0 = 16'h8000 -> S_RST_WAIT -> S_RST_RD.
//   - S_RST_RD/S_RST_RDWAIT: read reg 0.
//       bit15 = 0 -> S_AN_WR.
//       bit15 = 1 -> retry after WRITE_WAIT_CYCLES gap; after RESET_POLL_MAX reads, set init_fault -> S_AN_WR.
//       timeout -> smi_timeout = 1, restart at S_POWERUP.
//   - S_AN_WR/S_AN_WAIT: write reg 0 = 16'h1200 (AN enable + restart).
//       Completion -> init_done = 1, timer = POLL_INTERVAL -> S_POLL_IDLE.
//   - S_POLL_IDLE: timer expiry -> S_BMSR_RD; read reg 1; new_link = out_data[2].
//       new_link 0: link_up <= 0 -> S_POLL_IDLE.
//       new_link 1 and link_up was 0 -> S_SPD_RD.
//       new_link 1 and link_up was 1 -> S_POLL_IDLE.
//       Timeout: smi_timeout = 1, treated as new_link = 0.
//   - S_SPD_RD/S_SPD_WAIT: read reg 31 (HCDSPEED = out_data[4:2]).
//       speed_100 = out_data[3], full_duplex = out_data[4], link_up <= 1 -> S_POLL_IDLE.
//       Timeout: smi_timeout = 1, link stays 0.
//  link_change pulses the cycle after link_up changes value; it never pulses on reset.
//  On link down, speed_100/full_duplex keep their last values (do not-care).
//  rst asserted mid-transaction aborts immediately. smi_device is reset by the same rst, so no frame completion is awaited.
//  Timer: single down-counter sized $clog2(max of cycle params)+1 bits, reloaded on every state entry that uses it. Reaching 0 = expiry.
// STRUCTURE
//  smi_pkg:
//   - register addresses (BMCR = 0, BMSR = 1, PHY_SCSR = 31), bit indices, BMCR command words.
//   - state enum smi_mgr_state_t.
//  Single module, no sub-modules. FSM plus one shared timer plus a retry counter ($clog2(RESET_POLL_MAX+1) bits).
// TESTING (sim params: POWERUP 100, WRITE_WAIT 50, READ_TIMEOUT 64, POLL 500, RESET_POLL_MAX 4; behavioural smi_device stub)
//  1. Reset release -> first do_write at cycle 100 with reg_addr = 0, in_data = 16'h8000; no request before.
//  2. Stub returns BMCR = 8000, 8000, 0000 -> 3 reads, then write 16'h1200; init_done = 1, init_fault = 0.
//  3. BMCR always 8000 -> exactly 4 reads, init_fault = 1, AN write still issued.
//  4. BMSR = 16'h0004, reg31 = 16'h0018 -> link_up = 1, speed_100 = 1, full_duplex = 1, one link_change pulse.
//  5. Then BMSR = 0 -> link_up = 0 at next poll, one link_change pulse, no reg31 read.
//  6. Stub never answers a BMSR read -> after 64 cycles smi_timeout = 1, link_up = 0; polling continues at POLL_INTERVAL.

Source files
------------

// File: rtl/smi_pkg.sv
// Shared definitions for the SMI PHY management sequencer: LAN8720 register map,
// command words and the sequencer state encoding.
package smi_pkg;

   localparam logic [4:0] REG_BMCR     = 5'd0;
   localparam logic [4:0] REG_BMSR     = 5'd1;
   localparam logic [4:0] REG_PHY_SCSR = 5'd31;

   localparam int unsigned BMCR_RESET_BIT    = 15;
   localparam int unsigned BMSR_LINK_BIT     = 2;
   localparam int unsigned SCSR_SPEED100_BIT = 3;
   localparam int unsigned SCSR_FDX_BIT      = 4;

   localparam logic [15:0] BMCR_SOFT_RESET = 16'h8000;
   localparam logic [15:0] BMCR_AN_RESTART = 16'h1200;

   typedef enum logic [3:0] {
      S_POWERUP,
      S_RST_WR,
      S_RST_WAIT,
      S_RST_RD,
      S_RST_RDWAIT,
      S_RST_GAP,
      S_AN_WR,
      S_AN_WAIT,
      S_POLL_IDLE,
      S_BMSR_RD,
      S_BMSR_WAIT,
      S_SPD_RD,
      S_SPD_WAIT
   } smi_mgr_state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/smi_phy_manager.sv
// Drives smi_device to soft-reset the PHY, start auto-negotiation, then polls
// link status and publishes link_up / speed_100 / full_duplex.
module smi_phy_manager
   import smi_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR          = 5'd1,
   parameter int unsigned POWERUP_CYCLES    = 1_000_000,
   parameter int unsigned WRITE_WAIT_CYCLES = 3000,
   parameter int unsigned READ_TIMEOUT      = 4096,
   parameter int unsigned POLL_INTERVAL     = 10_000_000,
   parameter int unsigned RESET_POLL_MAX    = 16
) (
   input  logic        clk_100mhz,
   input  logic        rst,
   output logic [4:0]  phy_addr,
   output logic [4:0]  reg_addr,
   output logic [15:0] in_data,
   output logic        do_read,
   output logic        do_write,
   input  logic [15:0] out_data,
   input  logic        out_data_valid,
   output logic        init_done,
   output logic        link_up,
   output logic        speed_100,
   output logic        full_duplex,
   output logic        link_change,
   output logic        smi_timeout,
   output logic        init_fault
);

   localparam int unsigned MAX_CYC = max_u(max_u(POWERUP_CYCLES, WRITE_WAIT_CYCLES),
                                           max_u(READ_TIMEOUT, POLL_INTERVAL));
   localparam int unsigned TW = $clog2(MAX_CYC) + 1;
   localparam int unsigned RW = $clog2(RESET_POLL_MAX + 1);

   // Timers are loaded with N-1 so that a state lasts exactly N cycles.
   localparam logic [TW-1:0] T_POWERUP = TW'(POWERUP_CYCLES - 1);
   localparam logic [TW-1:0] T_WRITE   = TW'(WRITE_WAIT_CYCLES - 1);
   localparam logic [TW-1:0] T_READ    = TW'(READ_TIMEOUT - 1);
   localparam logic [TW-1:0] T_POLL    = TW'(POLL_INTERVAL - 1);
   localparam logic [RW-1:0] LAST_TRY  = RW'(RESET_POLL_MAX - 1);

   smi_mgr_state_t state, next_state;
   logic [TW-1:0]  timer, timer_val;
   logic [RW-1:0]  retry_cnt;
   logic           link_prev;

   logic           timer_load, req_load, retry_clr, retry_inc;
   logic [4:0]     req_reg;
   logic [15:0]    req_data;
   logic           set_fault, set_timeout, set_init, link_clr, link_set;
   logic           expired;

   logic           unused_bits;
   assign unused_bits = ^{out_data[14:5], out_data[1:0]};

   assign phy_addr    = PHY_ADDR;
   assign link_change = link_up ^ link_prev;
   assign expired     = (timer == '0);

   always_comb begin
      next_state  = state;
      timer_load  = 1'b0;
      timer_val   = '0;
      do_read     = 1'b0;
      do_write    = 1'b0;
      req_load    = 1'b0;
      req_reg     = reg_addr;
      req_data    = in_data;
      retry_clr   = 1'b0;
      retry_inc   = 1'b0;
      set_fault   = 1'b0;
      set_timeout = 1'b0;
      set_init    = 1'b0;
      link_clr    = 1'b0;
      link_set    = 1'b0;

      case (state)
         S_POWERUP: if (expired) begin
            next_state = S_RST_WR;
            req_load   = 1'b1;
            req_reg    = REG_BMCR;
            req_data   = BMCR_SOFT_RESET;
            retry_clr  = 1'b1;
         end
         S_RST_WR: begin
            do_write   = 1'b1;
            next_state = S_RST_WAIT;
            timer_load = 1'b1;
            timer_val  = T_WRITE;
         end
         S_RST_WAIT, S_RST_GAP: if (expired) begin
            next_state = S_RST_RD;
            req_load   = 1'b1;
            req_reg    = REG_BMCR;
         end
         S_RST_RD: begin
            do_read    = 1'b1;
            next_state = S_RST_RDWAIT;
            timer_load = 1'b1;
            timer_val  = T_READ;
         end
         S_RST_RDWAIT: begin
            if (out_data_valid) begin
               if (out_data[BMCR_RESET_BIT] && retry_cnt != LAST_TRY) begin
                  retry_inc  = 1'b1;
                  next_state = S_RST_GAP;
                  timer_load = 1'b1;
                  timer_val  = T_WRITE;
               end else begin
                  set_fault  = out_data[BMCR_RESET_BIT];
                  next_state = S_AN_WR;
                  req_load   = 1'b1;
                  req_reg    = REG_BMCR;
                  req_data   = BMCR_AN_RESTART;
               end
            end else if (expired) begin
               set_timeout = 1'b1;
               next_state  = S_POWERUP;
               timer_load  = 1'b1;
               timer_val   = T_POWERUP;
            end
         end
         S_AN_WR: begin
            do_write   = 1'b1;
            next_state = S_AN_WAIT;
            timer_load = 1'b1;
            timer_val  = T_WRITE;
         end
         S_AN_WAIT: if (expired) begin
            set_init   = 1'b1;
            next_state = S_POLL_IDLE;
            timer_load = 1'b1;
            timer_val  = T_POLL;
         end
         S_POLL_IDLE: if (expired) begin
            next_state = S_BMSR_RD;
            req_load   = 1'b1;
            req_reg    = REG_BMSR;
         end
         S_BMSR_RD, S_SPD_RD: begin
            do_read    = 1'b1;
            next_state = (state == S_BMSR_RD) ? S_BMSR_WAIT : S_SPD_WAIT;
            timer_load = 1'b1;
            timer_val  = T_READ;
         end
         S_BMSR_WAIT: begin
            if (out_data_valid && out_data[BMSR_LINK_BIT] && !link_up) begin
               next_state = S_SPD_RD;
               req_load   = 1'b1;
               req_reg    = REG_PHY_SCSR;
            end else if (out_data_valid || expired) begin
               set_timeout = !out_data_valid;
               link_clr    = !out_data_valid || !out_data[BMSR_LINK_BIT];
               next_state  = S_POLL_IDLE;
               timer_load  = 1'b1;
               timer_val   = T_POLL;
            end
         end
         S_SPD_WAIT: if (out_data_valid || expired) begin
            set_timeout = !out_data_valid;
            link_set    = out_data_valid;
            next_state  = S_POLL_IDLE;
            timer_load  = 1'b1;
            timer_val   = T_POLL;
         end
         default: begin
            next_state = S_POWERUP;
            timer_load = 1'b1;
            timer_val  = T_POWERUP;
         end
      endcase
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state       <= S_POWERUP;
         timer       <= T_POWERUP;
         retry_cnt   <= '0;
         reg_addr    <= '0;
         in_data     <= '0;
         init_done   <= 1'b0;
         link_up     <= 1'b0;
         link_prev   <= 1'b0;
         speed_100   <= 1'b0;
         full_duplex <= 1'b0;
         smi_timeout <= 1'b0;
         init_fault  <= 1'b0;
      end else begin
         state     <= next_state;
         link_prev <= link_up;
         if (timer_load)
            timer <= timer_val;
         else if (!expired)
            timer <= timer - 1'b1;
         if (retry_clr)
            retry_cnt <= '0;
         else if (retry_inc)
            retry_cnt <= retry_cnt + 1'b1;
         if (req_load) begin
            reg_addr <= req_reg;
            in_data  <= req_data;
         end
         if (set_init)
            init_done <= 1'b1;
         if (set_fault)
            init_fault <= 1'b1;
         if (set_timeout)
            smi_timeout <= 1'b1;
         if (link_clr)
            link_up <= 1'b0;
         if (link_set) begin
            link_up     <= 1'b1;
            speed_100   <= out_data[SCSR_SPEED100_BIT];
            full_duplex <= out_data[SCSR_FDX_BIT];
         end
      end
   end

endmodule

// File: tb/tb_smi_phy_manager.sv
// Bench for smi_phy_manager: behavioural smi_device stub with random latency,
// directed scenarios plus randomized PHY register contents.
module tb_smi_phy_manager;

   localparam int unsigned POWERUP = 100;
   localparam int unsigned WWAIT   = 50;
   localparam int unsigned RTO     = 64;
   localparam int unsigned POLL    = 500;
   localparam int unsigned RPMAX   = 4;

   logic        clk_100mhz = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  phy_addr, reg_addr;
   logic [15:0] in_data;
   logic        do_read, do_write;
   logic [15:0] out_data = '0;
   logic        out_data_valid = 1'b0;
   logic        init_done, link_up, speed_100, full_duplex, link_change;
   logic        smi_timeout, init_fault;

   smi_phy_manager #(
      .PHY_ADDR(5'd1), .POWERUP_CYCLES(POWERUP), .WRITE_WAIT_CYCLES(WWAIT),
      .READ_TIMEOUT(RTO), .POLL_INTERVAL(POLL), .RESET_POLL_MAX(RPMAX)
   ) dut (
      .clk_100mhz(clk_100mhz), .rst(rst), .phy_addr(phy_addr), .reg_addr(reg_addr),
      .in_data(in_data), .do_read(do_read), .do_write(do_write), .out_data(out_data),
      .out_data_valid(out_data_valid), .init_done(init_done), .link_up(link_up),
      .speed_100(speed_100), .full_duplex(full_duplex), .link_change(link_change),
      .smi_timeout(smi_timeout), .init_fault(init_fault)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   int total = 0;
   int bad   = 0;

   // stub configuration (written by the stimulus only)
   logic [15:0] bmcr_seq [8];
   int          bmcr_len;
   logic [15:0] bmcr_default, bmsr_val, scsr_val;
   bit          bmsr_silent;

   // stub / monitor state (written by the stub only)
   int          cyc;
   int          pend;
   logic [4:0]  pend_reg;
   int          bmcr_idx;
   int          rd_cnt [32];
   int          wr_cnt;
   logic [15:0] wr_first_data, wr_last_data;
   logic [4:0]  wr_first_reg;
   int          wr_first_cyc, rd_before_wr, lc_cnt, both_cnt;

   always @(posedge clk_100mhz) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk_100mhz) begin
      out_data_valid = 1'b0;
      if (rst) begin
         pend = -1;
         bmcr_idx = 0;
         foreach (rd_cnt[i]) rd_cnt[i] = 0;
         wr_cnt = 0; wr_first_cyc = -1; rd_before_wr = 0; lc_cnt = 0; both_cnt = 0;
         wr_first_data = '0; wr_last_data = '0; wr_first_reg = '0;
      end else begin
         if (pend > 0) pend--;
         else if (pend == 0) begin
            out_data_valid = 1'b1;
            if (pend_reg == 5'd0) begin
               if (bmcr_idx < bmcr_len) begin
                  out_data = bmcr_seq[bmcr_idx];
                  bmcr_idx++;
               end else out_data = bmcr_default;
            end else if (pend_reg == 5'd1) out_data = bmsr_val;
            else out_data = scsr_val;
            pend = -1;
         end
         if (do_read && do_write) both_cnt++;
         if (do_read) begin
            rd_cnt[reg_addr]++;
            if (wr_cnt == 0) rd_before_wr++;
            if (!(bmsr_silent && reg_addr == 5'd1)) begin
               pend = int'($urandom_range(1, 20));
               pend_reg = reg_addr;
            end
         end
         if (do_write) begin
            if (wr_cnt == 0) begin
               wr_first_cyc = cyc; wr_first_data = in_data; wr_first_reg = reg_addr;
            end
            wr_last_data = in_data;
            wr_cnt++;
         end
         if (link_change) lc_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_100mhz);
      rst = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      check("reset_state",
            {27'd0, phy_addr, do_read, do_write, init_done, link_up, speed_100,
             full_duplex, link_change, smi_timeout, init_fault},
            {27'd0, 5'd1, 9'd0});
      rst = 1'b0;
   endtask

   task automatic wait_init(input int limit);
      for (int i = 0; i < limit && !init_done; i++) @(negedge clk_100mhz);
      check("init_done", 32'(init_done), 32'd1);
   endtask

   initial begin
      int r0, k, exp_reads;
      logic exp_link;

      // scenario 1/2: soft reset clears after three BMCR reads
      bmcr_seq[0] = 16'h8000; bmcr_seq[1] = 16'h8000; bmcr_seq[2] = 16'h0000;
      bmcr_len = 3; bmcr_default = 16'h0000; bmsr_val = 16'h0000; scsr_val = 16'h0000;
      bmsr_silent = 1'b0;
      apply_reset();
      for (int i = 0; i < 300 && wr_cnt == 0; i++) @(negedge clk_100mhz);
      check("first_wr_cycle", 32'(wr_first_cyc), 32'(POWERUP));
      check("first_wr_reg", 32'(wr_first_reg), 32'd0);
      check("first_wr_data", 32'(wr_first_data), 32'h8000);
      check("no_read_before_wr", 32'(rd_before_wr), 32'd0);
      wait_init(2000);
      check("bmcr_reads_3", 32'(rd_cnt[0]), 32'd3);
      check("an_write", 32'(wr_last_data), 32'h1200);
      check("write_count", 32'(wr_cnt), 32'd2);
      check("no_fault", 32'(init_fault), 32'd0);

      // scenario 3: soft reset never clears
      bmcr_len = 0; bmcr_default = 16'h8000;
      apply_reset();
      wait_init(3000);
      check("bmcr_reads_max", 32'(rd_cnt[0]), 32'(RPMAX));
      check("init_fault", 32'(init_fault), 32'd1);
      check("an_write_after_fault", 32'(wr_last_data), 32'h1200);

      // scenario 4: link comes up at 100M full duplex
      bmcr_default = 16'h0000; bmsr_val = 16'h0004; scsr_val = 16'h0018;
      apply_reset();
      for (int i = 0; i < 3000 && !link_up; i++) @(negedge clk_100mhz);
      check("link_up", 32'(link_up), 32'd1);
      check("speed_100", 32'(speed_100), 32'd1);
      check("full_duplex", 32'(full_duplex), 32'd1);
      repeat (1200) @(negedge clk_100mhz);
      check("link_change_up", 32'(lc_cnt), 32'd1);
      check("scsr_reads_once", 32'(rd_cnt[31]), 32'd1);

      // scenario 5: link drops
      bmsr_val = 16'h0000;
      for (int i = 0; i < 1500 && link_up; i++) @(negedge clk_100mhz);
      repeat (5) @(negedge clk_100mhz);
      check("link_down", 32'(link_up), 32'd0);
      check("link_change_down", 32'(lc_cnt), 32'd2);
      check("no_scsr_on_down", 32'(rd_cnt[31]), 32'd1);

      // scenario 6: BMSR read never answered
      bmsr_silent = 1'b1;
      for (int i = 0; i < 1500 && !smi_timeout; i++) @(negedge clk_100mhz);
      check("smi_timeout", 32'(smi_timeout), 32'd1);
      check("link_after_timeout", 32'(link_up), 32'd0);
      r0 = rd_cnt[1];
      repeat (1200) @(negedge clk_100mhz);
      check("poll_continues", 32'(rd_cnt[1] - r0), 32'd2);
      check("timeout_sticky", 32'(smi_timeout), 32'd1);
      bmsr_silent = 1'b0;

      // randomized rounds: model derives outcome from register contents
      for (int n = 0; n < 4; n++) begin
         k = int'($urandom_range(0, 5));
         for (int j = 0; j < 8; j++) bmcr_seq[j] = (j < k) ? 16'h8000 : 16'h0000;
         bmcr_len = k + 1; bmcr_default = 16'h0000;
         bmsr_val = 16'($urandom) & 16'hfffb;
         if (n[0] == 1'b0) bmsr_val[2] = 1'b1;
         scsr_val = 16'($urandom);
         exp_reads = (k + 1 < int'(RPMAX)) ? k + 1 : int'(RPMAX);
         exp_link = bmsr_val[2];
         apply_reset();
         wait_init(3000);
         check("rnd_bmcr_reads", 32'(rd_cnt[0]), 32'(exp_reads));
         check("rnd_fault", 32'(init_fault), 32'(k >= int'(RPMAX)));
         for (int i = 0; i < 1000 && rd_cnt[1] == 0; i++) @(negedge clk_100mhz);
         repeat (80) @(negedge clk_100mhz);
         check("rnd_link", 32'(link_up), 32'(exp_link));
         check("rnd_scsr_reads", 32'(rd_cnt[31]), 32'(exp_link));
         if (exp_link) begin
            check("rnd_speed", 32'(speed_100), 32'(scsr_val[3]));
            check("rnd_duplex", 32'(full_duplex), 32'(scsr_val[4]));
         end
         check("rnd_no_timeout", 32'(smi_timeout), 32'd0);
      end

      check("never_rd_and_wr", 32'(both_cnt), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
